// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT/INTT sizing constants
package ntt_pkg;

  localparam int COEF_WIDTH     = 12;
  localparam int PAIR_WIDTH     = 2 * COEF_WIDTH;
  localparam int OUT_FIFO_DEPTH = 16;

endpackage

// File: rtl/ntt_out_fifo_wrap_ptr.sv
// rtl/ntt_out_fifo_wrap_ptr.sv - wrapping pointer counter for the output FIFO
module wrap_ptr #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  // DEPTH is a power of two, so the binary rollover is the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/ntt_out_fifo.sv
// rtl/ntt_out_fifo.sv - FWFT elastic buffer after the NTT pipeline; NTT_OUT_FIFO_HWM_EN adds max_level
module ntt_out_fifo
  import ntt_pkg::*;
#(
  parameter int WIDTH    = PAIR_WIDTH,
  parameter int DEPTH    = OUT_FIFO_DEPTH,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     afull,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef NTT_OUT_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]   max_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    next_count;
  logic             push;
  logic             pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && ((count < CW'(DEPTH)) || pop);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    next_count = count;
    case ({push, pop})
      2'b10:   next_count = count + CW'(1);
      2'b01:   next_count = count - CW'(1);
      default: next_count = count;
    endcase
  end

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Payload storage is not reset; out_valid alone qualifies it
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      afull    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count <= next_count;
      afull <= (next_count >= CW'(AFULL_TH));
      if (in_valid && !push)
        overflow <= 1'b1;
    end
  end

`ifdef NTT_OUT_FIFO_HWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      max_level <= '0;
    else if (next_count > max_level)
      max_level <= next_count;
  end
`endif

endmodule

// File: tb/tb_ntt_out_fifo.sv
// tb/tb_ntt_out_fifo.sv - self-checking bench for ntt_out_fifo (max_level checked when NTT_OUT_FIFO_HWM_EN)
module tb_ntt_out_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        afull;
  logic        out_valid;
  logic [23:0] out_data;
  logic [4:0]  count;
  logic        overflow;
`ifdef NTT_OUT_FIFO_HWM_EN
  logic [4:0]  max_level;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] q[$];
  logic        m_overflow = 1'b0;
  int          m_max = 0;

  always #5 clk = ~clk;

  ntt_out_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .afull     (afull),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow)
`ifdef NTT_OUT_FIFO_HWM_EN
    ,
    .max_level (max_level)
`endif
  );

  typedef struct {
    logic        iv;
    logic [23:0] d;
    logic        rdy;
    logic        e_ov;
    logic        chk_d;
    logic [23:0] e_d;
    int          e_cnt;
    logic        e_af;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the queue model
  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".afull"}, 32'(afull), 32'(q.size() >= 12));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_overflow));
    if (q.size() != 0)
      chk({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
`ifdef NTT_OUT_FIFO_HWM_EN
    chk({tag, ".max_level"}, 32'(max_level), 32'(m_max));
`endif
  endtask

  task automatic cycle(input logic iv, input logic [23:0] d, input logic rdy, input string tag);
    logic m_pop, m_push;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    m_pop  = (q.size() != 0) && rdy;
    m_push = iv && ((q.size() < 16) || m_pop);
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(d);
    if (iv && !m_push) m_overflow = 1'b1;
    if (q.size() > m_max) m_max = q.size();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #2;
    q.delete();
    m_overflow = 1'b0;
    m_max = 0;
    chk_model("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 24'hABC123, 1'b0, 1'b1, 1'b1, 24'hABC123, 1, 1'b0};
    vecs[1] = '{1'b1, 24'h000111, 1'b1, 1'b1, 1'b1, 24'h000111, 1, 1'b0};
    vecs[2] = '{1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h0,      0, 1'b0};
    vecs[3] = '{1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h0,      0, 1'b0};
    vecs[4] = '{1'b1, 24'h000222, 1'b0, 1'b1, 1'b1, 24'h000222, 1, 1'b0};
    vecs[5] = '{1'b1, 24'h000333, 1'b0, 1'b1, 1'b1, 24'h000222, 2, 1'b0};
    vecs[6] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 24'h000222, 2, 1'b0};
    vecs[7] = '{1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h000333, 1, 1'b0};
    vecs[8] = '{1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h0,      0, 1'b0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.afull", i), 32'(afull), 32'(vecs[i].e_af));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'h0);
      if (vecs[i].chk_d)
        chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_d));
    end

    // Fill: afull appears exactly when count reaches 12, head stays 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 24'(i), 1'b0, "fill");
      chk("fill.afull_hand", 32'(afull), 32'(i + 1 >= 12));
      chk("fill.head_hand", 32'(out_data), 32'h0);
    end
    chk("fill.count_full", 32'(count), 32'd16);

    // Overflow on full with no pop, then drain
    cycle(1'b1, 24'd99, 1'b0, "ovf");
    chk("ovf.overflow_hand", 32'(overflow), 32'h1);
    chk("ovf.count_hand", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain.order_hand", 32'(out_data), 32'(i));
      cycle(1'b0, 24'h0, 1'b1, "drain");
    end
    chk("drain.empty_hand", 32'(out_valid), 32'h0);
    chk("drain.overflow_sticky", 32'(overflow), 32'h1);

    // Full pass-through across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 24'(i), 1'b0, "pfill");
    for (int i = 0; i < 20; i++) begin
      chk("pass.order_hand", 32'(out_data), 32'(i));
      cycle(1'b1, 24'(16 + i), 1'b1, "pass");
      chk("pass.count_hand", 32'(count), 32'd16);
    end
    chk("pass.overflow_hand", 32'(overflow), 32'h0);

    // Random traffic against the queue model
    do_reset();
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(1, 0) == 1, 24'($urandom), $urandom_range(9, 0) < 3, "rand");

    // Async reset mid-stream with count=7 and overflow set
    do_reset();
    for (int i = 0; i < 17; i++)
      cycle(1'b1, 24'(100 + i), 1'b0, "rfill");
    for (int i = 0; i < 9; i++)
      cycle(1'b0, 24'h0, 1'b1, "rdrain");
    chk("rst.pre_count", 32'(count), 32'd7);
    chk("rst.pre_overflow", 32'(overflow), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst.count", 32'(count), 32'h0);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.overflow", 32'(overflow), 32'h0);
    chk("rst.afull", 32'(afull), 32'h0);
`ifdef NTT_OUT_FIFO_HWM_EN
    chk("rst.max_level", 32'(max_level), 32'h0);
`endif
    q.delete();
    m_overflow = 1'b0;
    m_max = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 24'h000555, 1'b0, "post");
    chk("post.first", 32'(out_data), 32'h000555);
`ifdef NTT_OUT_FIFO_HWM_EN
    chk("post.max_level", 32'(max_level), 32'h1);
`endif
    cycle(1'b0, 24'h0, 1'b1, "post_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
